// File: rtl/mc_control.sv
// mc_control: multicycle MIPS control FSM with a timed memory handshake and a sticky trap.
// Build option MC_CTRL_BNE_EN adds bne (opcode 0x05) as a branch taken on ~zero.
module mc_control #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEMACC, WBACK, BRANCH, JUMP, TRAP} state_t;
    state_t state, next;
    logic [15:0] cnt;
    logic rtype, r_ok, is_lw, is_sw, is_addi, is_beq, is_bne, is_j, waiting, timed_out;

    function automatic logic [3:0] r_alu(input logic [5:0] f);
        return f == 6'h22 ? 4'd6 : f == 6'h24 ? 4'd0 : f == 6'h25 ? 4'd1 :
               f == 6'h27 ? 4'd12 : f == 6'h2A ? 4'd7 : 4'd2;
    endfunction

    assign rtype   = opcode == 6'h00;
    assign r_ok    = rtype && (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A});
    assign is_lw   = opcode == 6'h23;
    assign is_sw   = opcode == 6'h2B;
    assign is_addi = opcode == 6'h08;
    assign is_beq  = opcode == 6'h04;
    assign is_j    = opcode == 6'h02;
`ifdef MC_CTRL_BNE_EN
    assign is_bne  = opcode == 6'h05;
`else
    assign is_bne  = 1'b0;
`endif
    assign waiting   = mem_req && !mem_ready;
    assign timed_out = waiting && cnt == 16'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            cnt   <= 16'd0;
        end else begin
            state <= next;
            cnt   <= (waiting && next == state) ? cnt + 16'd1 : 16'd0;
        end
    end

    always_comb begin
        next = state;
        case (state)
            FETCH:  next = mem_ready ? DECODE : FETCH;
            DECODE: next = (r_ok || is_lw || is_sw || is_addi) ? EXEC :
                           (is_beq || is_bne) ? BRANCH : is_j ? JUMP : TRAP;
            EXEC:   next = (is_lw || is_sw) ? MEMACC : WBACK;
            MEMACC: next = !mem_ready ? MEMACC : is_sw ? FETCH : WBACK;
            WBACK:  next = FETCH;
            BRANCH: next = FETCH;
            JUMP:   next = FETCH;
            TRAP:   next = TRAP;
        endcase
        if (timed_out) next = TRAP;
    end

    // Outputs are forced low for the whole reset cycle so an abandoned instruction writes nothing.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 4'd0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'd1;
                    alu_op    = 4'd2;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                DECODE: begin
                    alu_src_b = 2'd3;
                    alu_op    = 4'd2;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = rtype ? 2'd0 : 2'd2;
                    alu_op    = rtype ? r_alu(funct) : 4'd2;
                end
                MEMACC: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = is_sw;
                end
                WBACK: begin
                    reg_we     = 1'b1;
                    reg_dst    = rtype;
                    mem_to_reg = is_lw;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 4'd6;
                    pc_src    = 2'd1;
                    pc_we     = is_bne ? !zero : zero;
                end
                JUMP: begin
                    pc_src = 2'd2;
                    pc_we  = 1'b1;
                end
                TRAP: illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized instruction stream checked cycle by cycle against a transaction-level model.
module tb_mc_control;
    localparam int TO = 4;
    logic clk = 1'b0, reset = 1'b1;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic zero = 1'b0, mem_ready = 1'b0;
    logic mem_req, mem_we, iord, ir_we, pc_we, alu_src_a, reg_we, reg_dst, mem_to_reg, illegal;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_op;
    logic [17:0] obs;
    int vectors = 0, miscompares = 0;

    mc_control #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                  alu_op, reg_we, reg_dst, mem_to_reg, illegal};

    localparam logic [17:0] REQ = 18'h20000, MWE = 18'h10000, IORD = 18'h08000, IRW = 18'h04000,
                            PCW = 18'h02000, SA = 18'h00400, RW = 18'h00008, RD = 18'h00004,
                            M2R = 18'h00002, ILL = 18'h00001;

    function automatic logic [17:0] fld(int ps, int sb, int op);
        return (18'(ps) << 11) | (18'(sb) << 8) | (18'(op) << 4);
    endfunction

    function automatic int alu_of(logic [5:0] f);
        case (f)
            6'h20: return 2;
            6'h22: return 6;
            6'h24: return 0;
            6'h25: return 1;
            6'h27: return 12;
            default: return 7;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic check(string tag, logic [17:0] got, logic [17:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(string tag, logic rdy, logic [17:0] exp);
        mem_ready = rdy;
        @(negedge clk);
        check(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_trap();
        repeat (3) begin
            zero = rb();
            step("trap", rb(), ILL);
        end
        reset = 1'b1;
        step("trap_reset", rb(), 18'd0);
        reset = 1'b0;
    endtask

    // Each instruction is expanded into its expected per-cycle output vectors from the ISA rules.
    task automatic run_instr(logic [5:0] op, logic [5:0] fn, logic z, int fw, int mw);
        logic rt, legal, mem_op, taken, bne_ok;
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        zero   = rb();
        if (fw >= TO) begin
            repeat (TO) step("fetch_wait", 1'b0, REQ | fld(0, 1, 2));
            expect_trap();
            return;
        end
        repeat (fw) step("fetch_wait", 1'b0, REQ | fld(0, 1, 2));
        step("fetch", 1'b1, REQ | IRW | PCW | fld(0, 1, 2));
        opcode = op;
        funct  = fn;
        zero   = z;
        step("decode", rb(), fld(0, 3, 2));
`ifdef MC_CTRL_BNE_EN
        bne_ok = op == 6'h05;
`else
        bne_ok = 1'b0;
`endif
        rt = op == 6'h00;
        mem_op = op == 6'h23 || op == 6'h2B;
        legal = (rt && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A}) || mem_op ||
                op == 6'h08 || op == 6'h04 || op == 6'h02 || bne_ok;
        if (!legal) begin
            expect_trap();
            return;
        end
        if (op == 6'h02) begin
            step("jump", rb(), PCW | fld(2, 0, 0));
            return;
        end
        if (op == 6'h04 || op == 6'h05) begin
            taken = op == 6'h04 ? z : !z;
            step("branch", rb(), (taken ? PCW : 18'd0) | SA | fld(1, 0, 6));
            return;
        end
        step("exec", rb(), SA | fld(0, rt ? 0 : 2, rt ? alu_of(fn) : 2));
        if (mem_op) begin
            if (mw >= TO) begin
                repeat (TO) step("mem_wait", 1'b0, REQ | IORD | (op == 6'h2B ? MWE : 18'd0));
                expect_trap();
                return;
            end
            repeat (mw) step("mem_wait", 1'b0, REQ | IORD | (op == 6'h2B ? MWE : 18'd0));
            step("mem", 1'b1, REQ | IORD | (op == 6'h2B ? MWE : 18'd0));
            if (op == 6'h2B) return;
        end
        step("wback", rb(), RW | (rt ? RD : 18'd0) | (op == 6'h23 ? M2R : 18'd0));
    endtask

    initial begin
        logic [5:0] ops [10];
        logic [5:0] fns [7];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02, 6'h00, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};
        mem_ready = 1'b1;
        step("reset0", 1'b1, 18'd0);
        opcode = 6'h23;
        step("reset1", 1'b1, 18'd0);
        reset = 1'b0;
        run_instr(6'h00, 6'h20, 1'b0, 0, 0);
        run_instr(6'h23, 6'h00, 1'b0, 0, 3);
        run_instr(6'h04, 6'h00, 1'b1, 1, 0);
        run_instr(6'h04, 6'h00, 1'b0, 0, 0);
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
        run_instr(6'h00, 6'h00, 1'b0, 0, 0);
        run_instr(6'h00, 6'h20, 1'b0, TO, 0);
        run_instr(6'h23, 6'h00, 1'b0, 0, TO);
        run_instr(6'h2B, 6'h00, 1'b0, TO - 1, TO - 1);
        run_instr(6'h05, 6'h00, 1'b0, 0, 0);
        run_instr(6'h05, 6'h00, 1'b1, 0, 0);
        run_instr(6'h02, 6'h00, 1'b0, 0, 0);
        run_instr(6'h08, 6'h00, 1'b0, 2, 0);
        step("fetch_mid", 1'b1, REQ | IRW | PCW | fld(0, 1, 2));
        opcode = 6'h00;
        funct  = 6'h22;
        step("decode_mid", 1'b0, fld(0, 3, 2));
        step("exec_mid", 1'b0, SA | fld(0, 0, 6));
        reset = 1'b1;
        step("reset_mid", 1'b1, 18'd0);
        reset = 1'b0;
        run_instr(6'h00, 6'h2A, 1'b0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            fn = ($urandom_range(0, 15) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
            run_instr(op, fn, rb(),
                      ($urandom_range(0, 24) == 0) ? TO : $urandom_range(0, TO - 1),
                      ($urandom_range(0, 24) == 0) ? TO : $urandom_range(0, TO - 1));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
